lc3_pipeline_controller: RTL and testbench

- Sequencing controller for the 5-stage LC-3 pipeline: fetch, decode, execute, writeback, memaccess.
- Consumes the control_in bus (completed_data, completed_instr, IR, NZP, PSR, IR_EXEC, Imem_dout).
- Produces per-stage enables, branch resolution, operand-bypass selects and the memory-access state.
- Sits between the instruction/data memory handshakes and the datapath stage registers; it is the DUT the control_in agent drives.

---
 rtl/lc3_ctrl_pkg.sv | 47 ++++
 rtl/lc3_mem_fsm.sv | 62 ++++++
 rtl/lc3_pipeline_controller.sv | 128 ++++++++++++
 tb/tb_lc3_pipeline_controller.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/lc3_ctrl_pkg.sv
// Shared definitions for the LC-3 pipeline controller.
//   - Opcode constants for IR[15:12].
//   - mem_state_t: memaccess state encoding (READ=0, READ_IND=1, WRITE=2, IDLE=3).
//   - Opcode class helpers used by the controller and the memaccess FSM.
package lc3_ctrl_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    typedef enum logic [1:0] {
        READ     = 2'd0,
        READ_IND = 2'd1,
        WRITE    = 2'd2,
        IDLE     = 2'd3
    } mem_state_t;

    function automatic logic is_alu(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
    endfunction

    function automatic logic is_alu_lea(input logic [3:0] op);
        return is_alu(op) || (op == OP_LEA);
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
    endfunction

    function automatic logic is_ctrl(input logic [3:0] op);
        return (op == OP_BR) || (op == OP_JMP);
    endfunction

endpackage

// File: rtl/lc3_mem_fsm.sv
// Memaccess state machine for the LC-3 pipeline controller.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   start_i             execute stage is enabled this cycle
//   op_i                opcode of the instruction in execute
//   completed_data_i    data memory finished the current access
//   state_o             current memaccess state (IDLE when no access)
//   load_wb_o           load result is ready for writeback this cycle
module lc3_mem_fsm
    import lc3_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [3:0] op_i,
    input  logic       completed_data_i,
    output mem_state_t state_o,
    output logic       load_wb_o
);

    mem_state_t state_q, state_d;
    // Remembers whether an indirect access is STI (pointer read then write)
    // or LDI (pointer read then read), so the execute opcode need not be held.
    logic       sti_q, sti_d;

    always_comb begin
        state_d = state_q;
        sti_d   = sti_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if ((op_i == OP_LD) || (op_i == OP_LDR)) begin
                        state_d = READ;
                    end else if ((op_i == OP_ST) || (op_i == OP_STR)) begin
                        state_d = WRITE;
                    end else if ((op_i == OP_LDI) || (op_i == OP_STI)) begin
                        state_d = READ_IND;
                        sti_d   = (op_i == OP_STI);
                    end
                end
            end
            READ_IND: if (completed_data_i) state_d = sti_q ? WRITE : READ;
            READ:     if (completed_data_i) state_d = IDLE;
            WRITE:    if (completed_data_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sti_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sti_q   <= sti_d;
        end
    end

    assign state_o   = state_q;
    assign load_wb_o = (state_q == READ) && completed_data_i;

endmodule

// File: rtl/lc3_pipeline_controller.sv
// Sequencing controller for the 5-stage LC-3 pipeline
// (fetch, decode, execute, writeback, memaccess).
// Ports:
//   clock, reset (async, active-low)
//   completed_instr, completed_data   memory handshakes
//   IR, IR_EXEC                       instructions in decode / execute
//   Imem_dout                         instruction memory word (not decoded here)
//   NZP, PSR                          branch condition field / condition codes
//   enable_*                          per-stage enables
//   br_taken                          PC redirect
//   bypass_alu_1/2, bypass_mem_1/2    operand forward selects
//   mem_state                         memaccess state (3 = idle)
module lc3_pipeline_controller
    import lc3_ctrl_pkg::*;
#(
    parameter int unsigned BR_BUBBLES = 3,
    parameter logic [1:0]  MEM_IDLE   = 2'b11
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        completed_instr,
    input  logic        completed_data,
    input  logic [15:0] IR,
    input  logic [15:0] IR_EXEC,
    input  logic [15:0] Imem_dout,
    input  logic [2:0]  NZP,
    input  logic [2:0]  PSR,
    output logic        enable_updatePC,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        br_taken,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2,
    output logic        bypass_mem_1,
    output logic        bypass_mem_2,
    output logic [1:0]  mem_state
);

    logic [3:0] v_q, v_d;       // {wb, ex, de, fe} valid
    logic [2:0] bub_q, bub_d;   // control-hazard bubble counter
    logic       stall;
    logic       fe_in;
    logic       ctrl_accept;
    logic       load_wb;
    mem_state_t ms;

    logic [3:0] op_d, op_x;
    logic [2:0] dst_x;
    logic       src1_hit, src2_hit, alu_src, ld_src;

    // Imem_dout is part of the control bus but the controller acts on IR
    // once the datapath has latched it; unused IR/IR_EXEC bits likewise.
    logic       sig_unused;
    assign sig_unused = ^{Imem_dout, IR[4:3], IR_EXEC[8:0]};

    assign op_d  = IR[15:12];
    assign op_x  = IR_EXEC[15:12];
    assign dst_x = IR_EXEC[11:9];

    assign mem_state = ms;
    assign stall     = (mem_state != MEM_IDLE) | ~completed_instr;

    assign enable_fetch     = v_q[0] & ~stall & (bub_q == 3'd0);
    assign enable_updatePC  = enable_fetch;
    assign enable_decode    = v_q[1] & ~stall;
    assign enable_execute   = v_q[2] & ~stall;
    assign enable_writeback = (v_q[3] & ~stall & is_alu_lea(op_x)) | load_wb;

    assign br_taken = enable_execute &
                      (((op_x == OP_BR) & (|(NZP & PSR))) | (op_x == OP_JMP));

    assign ctrl_accept = enable_decode & is_ctrl(op_d);

    always_comb begin
        bub_d = bub_q;
        if (!stall) begin
            if (ctrl_accept) begin
                bub_d = 3'(BR_BUBBLES);
            end else if (bub_q != 3'd0) begin
                bub_d = bub_q - 3'd1;
            end
        end
    end

    // The fetch slot is marked invalid whenever the counter is (or is about
    // to be) non-zero: this squashes the wrong-path fetch in the accept cycle
    // and lets the slot in the last bubble cycle refill, so fetch resumes
    // exactly BR_BUBBLES cycles after the accept.
    assign fe_in = (bub_d == 3'd0);
    assign v_d   = stall ? v_q : {v_q[2:0], fe_in};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v_q   <= '0;
            bub_q <= '0;
        end else begin
            v_q   <= v_d;
            bub_q <= bub_d;
        end
    end

    // Operand forwarding: source-1 and source-2 matches against the
    // destination of the instruction currently in execute.
    assign src1_hit = (dst_x == IR[8:6]) &
                      (is_alu(op_d) | (op_d == OP_LDR) | (op_d == OP_STR) | (op_d == OP_JMP));
    assign src2_hit = ((dst_x == IR[2:0]) & ((op_d == OP_ADD) | (op_d == OP_AND)) & ~IR[5]) |
                      ((dst_x == IR[11:9]) & is_store(op_d));
    assign alu_src  = v_q[2] & is_alu_lea(op_x);
    assign ld_src   = v_q[2] & is_load(op_x);

    assign bypass_alu_1 = alu_src & src1_hit;
    assign bypass_alu_2 = alu_src & src2_hit;
    assign bypass_mem_1 = ld_src & src1_hit;
    assign bypass_mem_2 = ld_src & src2_hit;

    lc3_mem_fsm u_mem_fsm (
        .clk_i            (clock),
        .rst_ni           (reset),
        .start_i          (enable_execute),
        .op_i             (op_x),
        .completed_data_i (completed_data),
        .state_o          (ms),
        .load_wb_o        (load_wb)
    );

endmodule

// File: tb/tb_lc3_pipeline_controller.sv
// Scoreboard bench for lc3_pipeline_controller: stimulus pushes the expected
// output vector for each cycle, a monitor on the falling edge pops/compares.
module tb_lc3_pipeline_controller;

    localparam logic [15:0] NOP_IR = 16'h1283;  // ADD R1,R2,R3
    localparam logic [15:0] NOP_X  = 16'h1FA1;  // ADD R7,R6,#1

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        completed_instr = 1'b1;
    logic        completed_data = 1'b0;
    logic [15:0] IR = NOP_IR;
    logic [15:0] IR_EXEC = NOP_X;
    logic [15:0] Imem_dout = 16'h0000;
    logic [2:0]  NZP = 3'b000;
    logic [2:0]  PSR = 3'b000;
    logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
    logic        br_taken, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
    logic [1:0]  mem_state;

    lc3_pipeline_controller #(.BR_BUBBLES(3), .MEM_IDLE(2'b11)) dut (
        .clock            (clock),
        .reset            (reset),
        .completed_instr  (completed_instr),
        .completed_data   (completed_data),
        .IR               (IR),
        .IR_EXEC          (IR_EXEC),
        .Imem_dout        (Imem_dout),
        .NZP              (NZP),
        .PSR              (PSR),
        .enable_updatePC  (enable_updatePC),
        .enable_fetch     (enable_fetch),
        .enable_decode    (enable_decode),
        .enable_execute   (enable_execute),
        .enable_writeback (enable_writeback),
        .br_taken         (br_taken),
        .bypass_alu_1     (bypass_alu_1),
        .bypass_alu_2     (bypass_alu_2),
        .bypass_mem_1     (bypass_mem_1),
        .bypass_mem_2     (bypass_mem_2),
        .mem_state        (mem_state)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       nm;
        logic [11:0] v;   // {pc,fe,de,ex,wb, br, ba1,ba2,bm1,bm2, mem_state}
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Inputs applied by the next step (besides IR / IR_EXEC).
    logic       s_rst = 1'b0;
    logic       s_ci  = 1'b1;
    logic       s_cd  = 1'b0;
    logic [2:0] s_nzp = 3'b000;
    logic [2:0] s_psr = 3'b000;

    // One cycle: drive inputs just after the rising edge (reset 1ns later, so
    // an assertion lands mid-cycle) and queue the expected outputs.
    task automatic step(input string nm, input logic [15:0] ir, input logic [15:0] irx,
                        input logic [4:0] en, input logic br, input logic [3:0] byp,
                        input logic [1:0] ms);
        exp_t e;
        @(posedge clock);
        #1;
        completed_instr = s_ci;
        completed_data  = s_cd;
        IR              = ir;
        IR_EXEC         = irx;
        NZP             = s_nzp;
        PSR             = s_psr;
        Imem_dout       = ir;
        #1;
        reset = s_rst;
        e.nm = nm;
        e.v  = {en, br, byp, ms};
        q.push_back(e);
    endtask

    // Warm-up after reset release: cycle 0 is the release cycle itself.
    task automatic warmup(input logic [15:0] ir, input logic [15:0] irx, input logic [3:0] byp);
        step("warm0", ir, irx, 5'b00000, 1'b0, 4'b0000, 2'd3);
        step("warm1", ir, irx, 5'b11000, 1'b0, 4'b0000, 2'd3);
        step("warm2", ir, irx, 5'b11100, 1'b0, 4'b0000, 2'd3);
        step("warm3", ir, irx, 5'b11110, 1'b0, byp,     2'd3);
        step("warm4", ir, irx, 5'b11111, 1'b0, byp,     2'd3);
    endtask

    // Remaining cycles after the branch reaches execute: fetch stays off
    // until the bubble drains, then the front end refills.
    task automatic bubble_tail(input string tag);
        step({tag, "_bub2"},   NOP_IR, NOP_X, 5'b00011, 1'b0, 4'b0000, 2'd3);
        step({tag, "_bub3"},   NOP_IR, NOP_X, 5'b00001, 1'b0, 4'b0000, 2'd3);
        step({tag, "_refill1"}, NOP_IR, NOP_X, 5'b11000, 1'b0, 4'b0000, 2'd3);
        step({tag, "_refill2"}, NOP_IR, NOP_X, 5'b11100, 1'b0, 4'b0000, 2'd3);
        step({tag, "_refill3"}, NOP_IR, NOP_X, 5'b11110, 1'b0, 4'b0000, 2'd3);
        step({tag, "_steady"},  NOP_IR, NOP_X, 5'b11111, 1'b0, 4'b0000, 2'd3);
    endtask

    // Monitor: compare on the falling edge, away from the active edge.
    initial begin
        logic [11:0] got;
        exp_t        e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e   = q.pop_front();
                got = {enable_updatePC, enable_fetch, enable_decode, enable_execute,
                       enable_writeback, br_taken, bypass_alu_1, bypass_alu_2,
                       bypass_mem_1, bypass_mem_2, mem_state};
                checks++;
                if (got !== e.v) begin
                    errors++;
                    $display("FAIL %s got=%b exp=%b (pc,fe,de,ex,wb,br,ba1,ba2,bm1,bm2,ms)",
                             e.nm, got, e.v);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        logic [15:0] brw [3];
        logic [2:0]  nzp [3];
        logic [2:0]  psr [3];
        logic        tk  [3];
        brw = '{16'h0405, 16'h0405, 16'h0005};
        nzp = '{3'b010,   3'b010,   3'b000};
        psr = '{3'b010,   3'b100,   3'b111};
        tk  = '{1'b1,     1'b0,     1'b0};

        // Reset state and warm-up with a plain ALU stream.
        step("reset0", NOP_IR, NOP_X, 5'b00000, 1'b0, 4'b0000, 2'd3);
        step("reset1", NOP_IR, NOP_X, 5'b00000, 1'b0, 4'b0000, 2'd3);
        s_rst = 1'b1;
        warmup(NOP_IR, NOP_X, 4'b0000);

        // LDI: indirect read then read, two wait cycles in each state.
        step("ldi_issue", NOP_IR, 16'hA200, 5'b11110, 1'b0, 4'b0000, 2'd3);
        for (int i = 0; i < 2; i++)
            step("ldi_ind_wait", NOP_IR, 16'hA200, 5'b00000, 1'b0, 4'b0000, 2'd1);
        s_cd = 1'b1;
        step("ldi_ind_done", NOP_IR, 16'hA200, 5'b00000, 1'b0, 4'b0000, 2'd1);
        s_cd = 1'b0;
        for (int i = 0; i < 2; i++)
            step("ldi_rd_wait", NOP_IR, 16'hA200, 5'b00000, 1'b0, 4'b0000, 2'd0);
        s_cd = 1'b1;
        step("ldi_wb", NOP_IR, 16'hA200, 5'b00001, 1'b0, 4'b0000, 2'd0);
        s_cd = 1'b0;
        step("ldi_after", NOP_IR, NOP_X, 5'b11111, 1'b0, 4'b0000, 2'd3);

        // Branches: taken, condition mismatch, nzp=000 never taken.
        for (int k = 0; k < 3; k++) begin
            s_nzp = nzp[k];
            s_psr = psr[k];
            step("br_accept", brw[k], NOP_X, 5'b11111, 1'b0, 4'b0000, 2'd3);
            step("br_exec", NOP_IR, brw[k], 5'b00110, tk[k], 4'b0000, 2'd3);
            bubble_tail("br");
        end

        // Bypass selects.
        step("byp_alu",    16'h12C3, 16'h16C2, 5'b11111, 1'b0, 4'b1100, 2'd3);
        step("byp_imm",    16'h12E3, 16'h16C2, 5'b11111, 1'b0, 4'b1000, 2'd3);
        step("byp_store",  16'h3600, 16'h16C2, 5'b11111, 1'b0, 4'b0100, 2'd3);
        step("byp_mem",    16'h12C3, 16'h66C0, 5'b11110, 1'b0, 4'b0011, 2'd3);
        s_cd = 1'b1;
        step("byp_mem_wb", 16'h12C3, 16'h66C0, 5'b00001, 1'b0, 4'b0011, 2'd0);
        s_cd = 1'b0;
        step("byp_clear",  NOP_IR, NOP_X, 5'b11111, 1'b0, 4'b0000, 2'd3);

        // Instruction-memory stall in the middle of a branch bubble.
        s_nzp = 3'b010;
        s_psr = 3'b010;
        step("st_accept", 16'h0405, NOP_X, 5'b11111, 1'b0, 4'b0000, 2'd3);
        s_ci = 1'b0;
        for (int i = 0; i < 2; i++)
            step("st_hold", NOP_IR, 16'h0405, 5'b00000, 1'b0, 4'b0000, 2'd3);
        s_ci = 1'b1;
        step("st_resume", NOP_IR, 16'h0405, 5'b00110, 1'b1, 4'b0000, 2'd3);
        bubble_tail("st");

        // STI, then asynchronous reset while in the write state.
        step("sti_issue", NOP_IR, 16'hB200, 5'b11110, 1'b0, 4'b0000, 2'd3);
        s_cd = 1'b1;
        step("sti_ind",   NOP_IR, 16'hB200, 5'b00000, 1'b0, 4'b0000, 2'd1);
        s_cd = 1'b0;
        step("sti_write", NOP_IR, 16'hB200, 5'b00000, 1'b0, 4'b0000, 2'd2);
        s_rst = 1'b0;
        step("async_rst", NOP_IR, 16'hB200, 5'b00000, 1'b0, 4'b0000, 2'd3);
        step("rst_hold",  16'h12C3, 16'h16C2, 5'b00000, 1'b0, 4'b0000, 2'd3);
        s_rst = 1'b1;
        // Matching operands: bypass must stay low until execute is valid.
        warmup(16'h12C3, 16'h16C2, 4'b1100);

        repeat (2) @(negedge clock);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
